// File: rtl/riscv_pc_fetch.sv
// rtl/riscv_pc_fetch.sv - program counter with request/grant fetch handshake and buffered redirects
module riscv_pc_fetch #(
    parameter int          DW        = 32,
    parameter logic [DW-1:0] RESET_VEC = '0,
    parameter bit          C_EXT     = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          trap_i,
    input  logic [DW-1:0] trap_vec_i,
    input  logic          redir_i,
    input  logic [DW-1:0] redir_pc_i,
    input  logic          rvc_i,
    input  logic          gnt_i,
    output logic          req_o,
    output logic [DW-1:0] PC_o,
    output logic [DW-1:0] PCN_o,
    output logic          pend_o,
    output logic          misalign_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] pc, pc_nx;
    logic [DW-1:0] pend_pc, pend_pc_nx;
    logic          pend, pend_nx;
    logic          pend_trap, pend_trap_nx;
    logic          mis, mis_nx;
    logic          load_tgt;

    logic          ev;
    logic [DW-1:0] tgt;
    logic [DW-1:0] inc;
    logic          mrg_valid;
    logic [DW-1:0] mrg_pc;
    logic          mrg_trap;

    // Event decode: trap wins over redirect, bit0 of any target is dropped.
    always_comb begin
        ev  = trap_i | redir_i;
        tgt = (trap_i ? trap_vec_i : redir_pc_i) & ~DW'(1);
        inc = (C_EXT && rvc_i) ? DW'(2) : DW'(4);
    end

    // Combine a new event with the buffered target: traps always replace,
    // redirects replace anything except a buffered trap.
    always_comb begin
        mrg_pc   = pend_pc;
        mrg_trap = pend_trap;
        if (trap_i) begin
            mrg_pc   = tgt;
            mrg_trap = 1'b1;
        end else if (redir_i && !(pend && pend_trap)) begin
            mrg_pc   = tgt;
            mrg_trap = 1'b0;
        end
        mrg_valid = pend | ev;
    end

    // Next-state, next-PC and pending-buffer logic.
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        pend_nx      = pend;
        pend_pc_nx   = pend_pc;
        pend_trap_nx = pend_trap;
        load_tgt     = 1'b0;
        req_o        = 1'b0;
        case (state)
            BOOT, STALL: begin
                // Nothing outstanding: targets go straight into the PC.
                if (mrg_valid) begin
                    pc_nx    = mrg_pc;
                    load_tgt = 1'b1;
                end
                pend_nx  = 1'b0;
                state_nx = stall_i ? STALL : REQ;
            end
            REQ: begin
                req_o = 1'b1;
                if (gnt_i) begin
                    // Granted address is committed; the target applies to the next one.
                    pc_nx    = mrg_valid ? mrg_pc : PCN_o;
                    load_tgt = mrg_valid;
                    pend_nx  = 1'b0;
                    state_nx = stall_i ? STALL : REQ;
                end else begin
                    // Address must stay stable until granted, so buffer the target.
                    pend_nx      = mrg_valid;
                    pend_pc_nx   = mrg_pc;
                    pend_trap_nx = mrg_trap;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
        mis_nx = load_tgt && !C_EXT && pc_nx[1];
    end

    // State, PC and pending-buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            pend      <= 1'b0;
            pend_pc   <= '0;
            pend_trap <= 1'b0;
            mis       <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            pend      <= pend_nx;
            pend_pc   <= pend_pc_nx;
            pend_trap <= pend_trap_nx;
            mis       <= mis_nx;
        end
    end

    // Output mapping.
    always_comb begin
        PC_o       = pc;
        PCN_o      = pc + inc;
        pend_o     = pend;
        misalign_o = mis;
    end

endmodule

// File: tb/tb_riscv_pc_fetch.sv
// tb/tb_riscv_pc_fetch.sv - table-driven scoreboard bench for riscv_pc_fetch
module tb_riscv_pc_fetch;

    typedef struct {
        logic        stall;
        logic        trap;
        logic [31:0] tvec;
        logic        redir;
        logic [31:0] rpc;
        logic        rvc;
        logic        gnt;
        logic        req;
        logic        pend;
        logic [31:0] pc_c;
        logic [31:0] pc_n;
        logic        mis_n;
    } vec_t;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam int RST_AT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, trap, redir, rvc, gnt;
    logic [31:0] tvec, rpc;

    logic        req_c, pend_c, mis_c;
    logic [31:0] pc_c, pcn_c;
    logic        req_n, pend_n, mis_n;
    logic [31:0] pc_n, pcn_n;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    riscv_pc_fetch #(.DW(32), .RESET_VEC(RV), .C_EXT(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .trap_i(trap), .trap_vec_i(tvec),
        .redir_i(redir), .redir_pc_i(rpc), .rvc_i(rvc), .gnt_i(gnt),
        .req_o(req_c), .PC_o(pc_c), .PCN_o(pcn_c), .pend_o(pend_c), .misalign_o(mis_c)
    );

    riscv_pc_fetch #(.DW(32), .RESET_VEC(RV), .C_EXT(1'b0)) u_n (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .trap_i(trap), .trap_vec_i(tvec),
        .redir_i(redir), .redir_pc_i(rpc), .rvc_i(rvc), .gnt_i(gnt),
        .req_o(req_n), .PC_o(pc_n), .PCN_o(pcn_n), .pend_o(pend_n), .misalign_o(mis_n)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic row(input logic s, input logic t, input logic [31:0] tv, input logic r,
                       input logic [31:0] rp, input logic c, input logic g, input logic eq,
                       input logic ep, input logic [31:0] epc, input logic [31:0] epn, input logic em);
        vec_t v;
        v.stall = s; v.trap = t; v.tvec = tv; v.redir = r; v.rpc = rp; v.rvc = c; v.gnt = g;
        v.req = eq; v.pend = ep; v.pc_c = epc; v.pc_n = epn; v.mis_n = em;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; trap = 1'b0; redir = 1'b0; rvc = 1'b0; gnt = 1'b0;
        tvec = '0; rpc = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        logic [31:0] inc_c;
        stall = v.stall; trap = v.trap; tvec = v.tvec; redir = v.redir;
        rpc = v.rpc; rvc = v.rvc; gnt = v.gnt;
        sb.push_back(v);
        @(posedge clk);
        #2;
        e = sb.pop_front();
        inc_c = e.rvc ? 32'd2 : 32'd4;
        chk("req_c", idx, {31'd0, req_c}, {31'd0, e.req});
        chk("req_n", idx, {31'd0, req_n}, {31'd0, e.req});
        chk("pend_c", idx, {31'd0, pend_c}, {31'd0, e.pend});
        chk("pend_n", idx, {31'd0, pend_n}, {31'd0, e.pend});
        chk("pc_c", idx, pc_c, e.pc_c);
        chk("pc_n", idx, pc_n, e.pc_n);
        chk("pcn_c", idx, pcn_c, e.pc_c + inc_c);
        chk("pcn_n", idx, pcn_n, e.pc_n + 32'd4);
        chk("mis_c", idx, {31'd0, mis_c}, 32'd0);
        chk("mis_n", idx, {31'd0, mis_n}, {31'd0, e.mis_n});
        @(negedge clk);
    endtask

    task automatic check_reset_state(input int idx);
        chk("rst_req_c", idx, {31'd0, req_c}, 32'd0);
        chk("rst_req_n", idx, {31'd0, req_n}, 32'd0);
        chk("rst_pc_c", idx, pc_c, RV);
        chk("rst_pc_n", idx, pc_n, RV);
        chk("rst_pend_c", idx, {31'd0, pend_c}, 32'd0);
        chk("rst_pend_n", idx, {31'd0, pend_n}, 32'd0);
        chk("rst_mis_n", idx, {31'd0, mis_n}, 32'd0);
    endtask

    task automatic mid_reset(input int idx);
        rst = 1'b1;
        #1;
        check_reset_state(idx);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state(idx);
    endtask

    initial begin
        //   stall trap tvec          redir rpc           rvc gnt  req pend pc_c          pc_n          mis_n
        // boot and sequential fetch
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, RV,            RV,            0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, RV + 32'h4,    RV + 32'h4,    0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, RV + 32'h8,    RV + 32'h8,    0);
        row(0, 0, 32'h0,         1, 32'h400,       0, 0,  1, 1, RV + 32'h8,    RV + 32'h8,    0);
        // after mid-stream reset
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, RV,            RV,            0);
        // rvc increments
        row(0, 0, 32'h0,         1, 32'h100,       0, 1,  1, 0, 32'h100,       32'h100,       0);
        row(0, 0, 32'h0,         0, 32'h0,         1, 1,  1, 0, 32'h102,       32'h104,       0);
        row(0, 0, 32'h0,         0, 32'h0,         1, 1,  1, 0, 32'h104,       32'h108,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h108,       32'h10C,       0);
        // buffered redirect
        row(0, 0, 32'h0,         1, 32'h200,       0, 1,  1, 0, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         1, 32'h400,       0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h400,       32'h400,       0);
        // priority
        row(0, 1, 32'h10,        1, 32'h400,       0, 1,  1, 0, 32'h10,        32'h10,        0);
        row(0, 0, 32'h0,         1, 32'h200,       0, 1,  1, 0, 32'h200,       32'h200,       0);
        row(0, 1, 32'h10,        0, 32'h0,         0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         1, 32'h400,       0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h10,        32'h10,        0);
        row(0, 0, 32'h0,         1, 32'h200,       0, 1,  1, 0, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         1, 32'h400,       0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 1, 32'h10,        0, 32'h0,         0, 0,  1, 1, 32'h200,       32'h200,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h10,        32'h10,        0);
        // events coincident with grant while buffered
        row(0, 0, 32'h0,         1, 32'h400,       0, 0,  1, 1, 32'h10,        32'h10,        0);
        row(0, 1, 32'h20,        0, 32'h0,         0, 1,  1, 0, 32'h20,        32'h20,        0);
        row(0, 1, 32'h30,        0, 32'h0,         0, 0,  1, 1, 32'h20,        32'h20,        0);
        row(0, 0, 32'h0,         1, 32'h400,       0, 1,  1, 0, 32'h30,        32'h30,        0);
        // stall
        row(1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h30,        32'h30,        0);
        row(1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h30,        32'h30,        0);
        row(1, 0, 32'h0,         0, 32'h0,         0, 1,  0, 0, 32'h34,        32'h34,        0);
        row(1, 0, 32'h0,         0, 32'h0,         0, 1,  0, 0, 32'h34,        32'h34,        0);
        row(1, 0, 32'h0,         1, 32'h300,       0, 0,  0, 0, 32'h300,       32'h300,       0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h300,       32'h300,       0);
        // wrap
        row(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 1,  1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
        row(0, 0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0,         0);
        row(0, 0, 32'h0,         1, 32'hFFFF_FFFE, 0, 1,  1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1);
        row(0, 0, 32'h0,         0, 32'h0,         1, 1,  1, 0, 32'h0,         32'h2,         0);
        // misalign and bit0 clearing
        row(0, 0, 32'h0,         1, 32'h106,       0, 1,  1, 0, 32'h106,       32'h106,       1);
        row(0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h106,       32'h106,       0);
        row(0, 0, 32'h0,         1, 32'h107,       0, 1,  1, 0, 32'h106,       32'h106,       1);
        row(0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h106,       32'h106,       0);

        rst = 1'b1;
        idle_inputs();
        gnt = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state(-1);
        rst = 1'b0;
        #1;
        check_reset_state(-1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == RST_AT) mid_reset(i);
            apply(tbl[i], i);
        end

        chk("sb_empty", -1, sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
